// File: rtl/la_status_pkg.sv
// Shared types and default sizing for the status-word arbiter that drives
// the upper user-area pads.
package la_status_pkg;

  localparam int DEF_NREQ   = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_HOLD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/la_rr_pick.sv
// Round-robin selector: the first active request at or after (last + 1),
// wrapping modulo NREQ. Purely combinational.
module la_rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    valid    = 1'b0;
    onehot   = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(last) + i) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid            = 1'b1;
        onehot[cand_idx] = 1'b1;
        idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/la_status_arbiter.sv
// Round-robin arbiter that presents the winning requester's status word on
// the pads for a programmable minimum number of cycles.
module la_status_arbiter
  import la_status_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     enable_i,
  input  logic [HOLD_W-1:0]        hold_cycles_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DATA_W-1:0]   data_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [$clog2(NREQ)-1:0]  owner_o,
  output logic                     busy_o,
  output logic [DATA_W-1:0]        io_out,
  output logic [DATA_W-1:0]        io_oeb
);

  localparam int IDX_W = $clog2(NREQ);

  state_t            state, state_next;
  logic [HOLD_W-1:0] cnt, cnt_next;
  logic              grant;

  logic              pick_valid;
  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;

  la_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_i),
    .last   (owner_o),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i && pick_valid) begin
          grant      = 1'b1;
          state_next = HOLD;
          // A zero hold still presents the word for one cycle.
          cnt_next   = (hold_cycles_i == '0) ? '0 : hold_cycles_i - 1'b1;
        end
      end
      HOLD: begin
        if (!enable_i || cnt == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_o   <= '0;
      owner_o <= IDX_W'(NREQ - 1);
      io_out  <= '0;
      io_oeb  <= '1;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      gnt_o  <= grant ? pick_onehot : '0;
      io_oeb <= {DATA_W{~enable_i}};
      // io_out is sticky: only a new grant replaces the presented word.
      if (grant) begin
        owner_o <= pick_idx;
        io_out  <= data_i[pick_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign busy_o = (state == HOLD);

endmodule

// File: tb/tb_la_status_arbiter.sv
// Scoreboard bench: a remaining-cycles reference model predicts every cycle
// and every grant; a separate monitor pops and compares.
module tb_la_status_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int HW   = 8;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [1:0]      owner;
    logic            busy;
    logic [DW-1:0]   out;
    logic [DW-1:0]   oeb;
  } obs_t;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [1:0]      owner;
    logic [DW-1:0]   data;
  } grant_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [HW-1:0]      hold;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt_o;
  logic [1:0]         owner_o;
  logic               busy_o;
  logic [DW-1:0]      io_out;
  logic [DW-1:0]      io_oeb;

  la_status_arbiter dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .enable_i      (en),
    .hold_cycles_i (hold),
    .req_i         (req),
    .data_i        (data),
    .gnt_o         (gnt_o),
    .owner_o       (owner_o),
    .busy_o        (busy_o),
    .io_out        (io_out),
    .io_oeb        (io_oeb)
  );

  always #5 clk = ~clk;

  obs_t   exp_q[$];
  grant_t grant_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     n_grants = 0;

  // Reference model state: HOLD cycles still to be presented, last owner,
  // presented word and pad enable.
  int            m_left  = 0;
  int            m_owner = NREQ - 1;
  logic [DW-1:0] m_out   = '0;
  logic [DW-1:0] m_oeb   = '1;
  bit            drop_on_grant = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Predict the outcome of the coming edge from the current inputs, queue
  // it, advance one cycle, then let a granted requester drop its request.
  task automatic step();
    obs_t   e;
    grant_t g;
    int     w;
    w     = -1;
    e.gnt = '0;
    if (rst) begin
      m_left  = 0;
      m_owner = NREQ - 1;
      m_out   = '0;
      m_oeb   = '1;
    end else begin
      m_oeb = en ? '0 : '1;
      if (m_left > 0) begin
        m_left = en ? m_left - 1 : 0;
      end else if (en && req != '0) begin
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(m_owner + k) % NREQ]) w = (m_owner + k) % NREQ;
        m_owner = w;
        m_out   = data[w*DW +: DW];
        m_left  = (hold == 0) ? 1 : int'(hold);
        e.gnt   = NREQ'(1 << w);
        g.gnt   = e.gnt;
        g.owner = 2'(w);
        g.data  = m_out;
        grant_q.push_back(g);
        n_grants++;
      end
    end
    e.owner = 2'(m_owner);
    e.busy  = (m_left > 0);
    e.out   = m_out;
    e.oeb   = m_oeb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (w >= 0 && drop_on_grant) req[w] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares every cycle and every grant pulse, independent of
  // the stimulus process.
  initial begin
    obs_t   e;
    grant_t g;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", 64'({gnt_o, owner_o, busy_o, io_out, io_oeb}), 64'(e));
      end
      if (gnt_o != '0) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 64'(gnt_o), 64'(0));
        end else begin
          g = grant_q.pop_front();
          check("grant", 64'({gnt_o, owner_o, io_out}), 64'(g));
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    hold = 8'd4;
    req  = 3'b111;
    data = {16'hAB51, 16'hAB41, 16'hAB40};

    // Reset with all requests held; first grant afterwards goes to 0.
    steps(3);
    rst = 1'b0;
    steps(16);

    // Single requester, hold of 4.
    req = 3'b001;
    steps(8);

    // All three requesting, hold of 2, each dropping on grant.
    hold = 8'd2;
    req  = 3'b111;
    steps(12);

    // Zero hold behaves as one cycle; continuous single requester.
    hold          = 8'd0;
    drop_on_grant = 1'b0;
    req           = 3'b010;
    steps(6);
    req           = 3'b000;
    drop_on_grant = 1'b1;
    steps(2);

    // Enable dropped on the second cycle of a 10-cycle hold.
    hold = 8'd10;
    req  = 3'b001;
    steps(2);
    en   = 1'b0;
    req  = 3'b011;
    steps(4);
    en   = 1'b1;
    steps(4);
    req  = 3'b000;
    steps(2);

    // Requests 0 and 2 held continuously.
    hold          = 8'd1;
    drop_on_grant = 1'b0;
    req           = 3'b101;
    steps(16);
    req           = 3'b000;
    drop_on_grant = 1'b1;
    steps(2);

    // Reset in the middle of a hold.
    hold = 8'd6;
    req  = 3'b010;
    steps(3);
    rst  = 1'b1;
    steps(2);
    rst  = 1'b0;
    steps(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) hold = HW'($urandom_range(0, 5));
      for (int n = 0; n < NREQ; n++) begin
        if (!req[n] && $urandom_range(0, 2) == 0) begin
          data[n*DW +: DW] = DW'($urandom);
          req[n]           = 1'b1;
        end
      end
      step();
    end

    rst = 1'b0;
    en  = 1'b1;
    req = '0;
    steps(12);
    @(posedge clk);
    #5;
    check("cycles_drained", 64'(exp_q.size()), 64'(0));
    check("grants_drained", 64'(grant_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/la_status_arbiter.md
LA_STATUS_ARBITER -- requirements
Module: la_status_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of requesters; DATA_W, default 16, status word width; HOLD_W, default 8, hold-counter width.
REQ-002 Port wb_clk_i SHALL be an input, 1 bit wide: the single clock.
REQ-003 Port wb_rst_i SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 Port enable_i SHALL be an input, 1 bit wide: arbitration and output-drive enable.
REQ-005 Port hold_cycles_i SHALL be an input, HOLD_W bits wide: minimum number of cycles each granted word is presented.
REQ-006 Port req_i SHALL be an input, NREQ bits wide: per-requester request, held until granted.
REQ-007 Port data_i SHALL be an input, NREQ*DATA_W bits wide: requester n's word in slice [n*DATA_W +: DATA_W], stable while req_i[n] is high.
REQ-008 Port gnt_o SHALL be an output, NREQ bits wide: one-hot, one-cycle acceptance pulse.
REQ-009 Port owner_o SHALL be an output, $clog2(NREQ) bits wide: index of the last granted requester.
REQ-010 Port busy_o SHALL be an output, 1 bit wide: high while in HOLD.
REQ-011 Port io_out SHALL be an output, DATA_W bits wide: status word to pads mprj_io[31:16].
REQ-012 Port io_oeb SHALL be an output, DATA_W bits wide: active-low pad output enable.

Function
REQ-013 The block SHALL implement an FSM with exactly two states, IDLE and HOLD.
REQ-014 In IDLE with enable_i=1 and req_i!=0, the next edge SHALL: select a winner round-robin, starting at (last owner+1) mod NREQ; register io_out<=winner data; register gnt_o<=one-hot winner; register owner_o<=winner; load the counter with max(hold_cycles_i,1)-1; enter HOLD.
REQ-015 gnt_o SHALL be high for exactly one cycle, the first HOLD cycle, and SHALL be zero otherwise.
REQ-016 In HOLD, the counter SHALL decrement each cycle; an edge that sees counter==0 SHALL return the FSM to IDLE.
REQ-017 Total HOLD duration SHALL be max(hold_cycles_i,1) cycles, with hold_cycles_i sampled only at grant.
REQ-018 The grant-to-next-grant spacing SHALL be at least HOLD duration + 1 cycle (one mandatory IDLE cycle).
REQ-019 req_i SHALL be ignored in HOLD; a request asserted during HOLD SHALL be arbitrated in the following IDLE.
REQ-020 io_out SHALL be sticky, keeping the last granted word after HOLD ends until the next grant.
REQ-021 io_oeb SHALL be all 0 while enable_i=1 and all 1 while enable_i=0, registered with one cycle of latency.
REQ-022 enable_i=0 during HOLD SHALL force IDLE at the next edge; gnt_o, if pending, SHALL not be repeated, and io_out SHALL be retained.
REQ-023 With all NREQ requests asserted, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-024 busy_o SHALL equal (state==HOLD).

Reset
REQ-025 On wb_rst_i=1 at an edge, the block SHALL set: state=IDLE, counter=0, gnt_o=0, owner_o=NREQ-1 (so requester 0 has first priority), io_out=0, io_oeb=all 1, busy_o=0.
REQ-026 Reset asserted mid-HOLD SHALL abort the hold; no grant SHALL be issued in the reset cycle.

Structure
REQ-027 Package la_status_pkg SHALL hold the state enum (IDLE, HOLD) and the default constants DATA_W=16, HOLD_W=8, NREQ=3.
REQ-028 Sub-module la_rr_pick SHALL be purely combinational and SHALL map (req vector, last owner) to (valid, one-hot, index); it is the only sub-module.

Verification
REQ-029 Reset with req_i=3'b111 held -> io_out=0, io_oeb=16'hFFFF, gnt_o=0 throughout reset; the first post-reset grant goes to requester 0.
REQ-030 enable_i=1, hold_cycles_i=4, req_i[0] with data 16'hAB40 -> gnt_o=3'b001 one cycle after request, io_out=16'hAB40, busy_o high for exactly 4 cycles, io_out still 16'hAB40 afterwards.
REQ-031 All three requesting AB40/AB41/AB51, hold_cycles_i=2, each dropping req on grant -> io_out sequence AB40, AB41, AB51, with each word stable 2 cycles and an IDLE gap of 1 cycle.
REQ-032 hold_cycles_i=0, single requester -> HOLD lasts 1 cycle and the grant period is 2 cycles.
REQ-033 enable_i dropped on the 2nd cycle of a 10-cycle hold -> busy_o low next cycle, io_oeb=16'hFFFF, io_out unchanged, no further gnt_o.
REQ-034 Requests 0 and 2 continuously asserted for 8 grants -> grant order 0,2,0,2,..., owner_o matching each grant.
